// File: rtl/seg7_scan_driver_if.sv
// Digit-capture inputs and multiplexed 7-segment display outputs of seg7_scan_driver.
interface seg7_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                  digit_valid;
    logic [3:0]            digit_in;
    logic                  hold;
    logic [6:0]            segments;
    logic                  dp;
    logic [NUM_DIGITS-1:0] digit_sel;

    modport master (
        output digit_valid, digit_in, hold,
        input  segments, dp, digit_sel
    );

    modport slave (
        input  digit_valid, digit_in, hold,
        output segments, dp, digit_sel
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Keeps a shift-register history of incoming digits and time-multiplexes it onto a
// common-cathode 7-segment display, with inter-digit blanking and a newest-digit marker.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 8,
    parameter int unsigned BLANK_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    seg7_scan_driver_if.slave   bus
);
    localparam int unsigned PHASE_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int unsigned SLOT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [3:0]            hist_q [NUM_DIGITS];
    logic [3:0]            hist_d [NUM_DIGITS];
    logic                  seen_q, seen_d;
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [6:0]            segments_q, segments_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;

    logic [3:0]            cur_digit;
    logic                  in_blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // History capture: newest digit enters slot 0, oldest falls off the end.
    always_comb begin
        hist_d = hist_q;
        seen_d = seen_q;
        if (bus.digit_valid && !bus.hold) begin
            hist_d[0] = bus.digit_in;
            for (int i = 1; i < int'(NUM_DIGITS); i++) begin
                hist_d[i] = hist_q[i-1];
            end
            seen_d = 1'b1;
        end
    end

    // Scan counters: phase within a slot, slot within a frame.
    always_comb begin
        phase_d = phase_q + PHASE_W'(1);
        slot_d  = slot_q;
        if (phase_q == PHASE_W'(SCAN_DIV - 1)) begin
            phase_d = '0;
            slot_d  = (slot_q == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot_q + SLOT_W'(1);
        end
    end

    assign cur_digit = hist_q[slot_q];
    assign in_blank  = (phase_q < PHASE_W'(BLANK_CYCLES));

    // Display outputs, one cycle behind the scan counters.
    always_comb begin
        digit_sel_d = '0;
        segments_d  = 7'h00;
        dp_d        = 1'b0;
        if (!in_blank) begin
            digit_sel_d = NUM_DIGITS'(1) << slot_q;
            dp_d        = (slot_q == '0) && seen_q;
            if (cur_digit <= 4'd9) begin
                segments_d = decode(cur_digit);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                hist_q[i] <= 4'hF;
            end
            seen_q      <= 1'b0;
            phase_q     <= '0;
            slot_q      <= '0;
            segments_q  <= 7'h00;
            dp_q        <= 1'b0;
            digit_sel_q <= '0;
        end else begin
            hist_q      <= hist_d;
            seen_q      <= seen_d;
            phase_q     <= phase_d;
            slot_q      <= slot_d;
            segments_q  <= segments_d;
            dp_q        <= dp_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    assign bus.segments  = segments_q;
    assign bus.dp        = dp_q;
    assign bus.digit_sel = digit_sel_q;
endmodule
